// File: rtl/ixc_ififo_arb.sv
// ixc_ififo_arb: packet-level round-robin write arbiter and pointer control for the GFIFO.
// Define IXC_IFIFO_ARB_WDOG_EN to add the XFER stall watchdog and ABORT state.

module ixc_ififo_arb #(
    parameter int NREQ = 4,
    parameter int DW   = 512,
    parameter int AW   = 14,
    parameter int LENW = 16
) (
    input  logic                 fclk,
    input  logic                 resetN,
    input  logic                 GFlock,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*LENW-1:0] req_len,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    input  logic [AW:0]          rptr,
    output logic                 wr_en,
    output logic [AW-1:0]        wr_addr,
    output logic [DW-1:0]        wr_data,
    output logic [AW:0]          wptr,
    output logic                 ackClk,
    output logic [AW+3:0]        ackLen,
    output logic [2:0]           gnt_id,
    output logic                 err_len
);

    localparam int CW = ((LENW > AW + 1) ? LENW : AW + 1) + 1;
    localparam logic [CW-1:0] DEPTH = CW'(1) << AW;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        XFER,
`ifdef IXC_IFIFO_ARB_WDOG_EN
        ABORT,
`endif
        COMMIT
    } state_t;

    state_t state_q, state_d;

    logic [AW:0]     xptr_q, wptr_q, len_q, rem_q;
    logic [AW:0]     used, free, pick_len;
    logic [2:0]      gnt_q, pick;
    logic            found, bad_hit;
    logic            any_valid, cur_valid, accept, last_word, grant;
    logic [NREQ-1:0] gnt_oh;
    logic [DW-1:0]   data_sel, wr_data_q;
    logic [AW-1:0]   wr_addr_q;
    logic            wr_en_q, err_q;

`ifdef IXC_IFIFO_ARB_WDOG_EN
    logic [7:0] stall_q;
    logic       stall_max;
`endif

    // Free space is judged against the speculative pointer and the live rptr.
    assign used      = xptr_q - rptr;
    assign free      = {1'b1, {AW{1'b0}}} - used;
    assign any_valid = |req_valid;
    assign gnt_oh    = NREQ'(1) << gnt_q;
    assign cur_valid = |(req_valid & gnt_oh);
    assign accept    = (state_q == XFER) && cur_valid;
    assign last_word = (rem_q == (AW+1)'(1));
    assign grant     = (state_q == ARB) && found && !GFlock;

    // Winner is the eligible requester nearest after the last grant; bad
    // lengths only count as errors when the search reaches them first.
    always_comb begin
        int pos;
        int best;
        logic [CW-1:0] cand_len;
        pos      = 0;
        best     = NREQ;
        cand_len = '0;
        found    = 1'b0;
        bad_hit  = 1'b0;
        pick     = gnt_q;
        pick_len = '0;
        for (int i = 0; i < NREQ; i++) begin
            pos      = (i - int'(gnt_q) - 1 + 8 * NREQ) % NREQ;
            cand_len = CW'(req_len[i*LENW +: LENW]);
            if (req_valid[i] && cand_len != '0 && cand_len <= DEPTH &&
                cand_len <= CW'(free) && pos < best) begin
                best     = pos;
                found    = 1'b1;
                pick     = 3'(i);
                pick_len = cand_len[AW:0];
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            pos      = (i - int'(gnt_q) - 1 + 8 * NREQ) % NREQ;
            cand_len = CW'(req_len[i*LENW +: LENW]);
            if (req_valid[i] && (cand_len == '0 || cand_len > DEPTH) &&
                pos < best) begin
                bad_hit = 1'b1;
            end
        end
    end

    always_comb begin
        data_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_q == 3'(i)) begin
                data_sel = req_data[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge fclk) begin
        if (!resetN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (any_valid && !GFlock) begin
                    state_d = ARB;
                end
            end
            ARB: begin
                if (grant) begin
                    state_d = XFER;
                end else begin
                    state_d = IDLE;
                end
            end
            XFER: begin
                if (accept && last_word) begin
                    state_d = COMMIT;
                end
`ifdef IXC_IFIFO_ARB_WDOG_EN
                else if (stall_max) begin
                    state_d = ABORT;
                end
`endif
            end
            COMMIT: begin
                if (any_valid && !GFlock) begin
                    state_d = ARB;
                end else begin
                    state_d = IDLE;
                end
            end
`ifdef IXC_IFIFO_ARB_WDOG_EN
            ABORT: begin
                state_d = IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready = '0;
        ackClk    = 1'b0;
        ackLen    = '0;
        if (state_q == XFER) begin
            req_ready = gnt_oh;
        end
        if (state_q == COMMIT) begin
            ackClk = 1'b1;
            ackLen = (AW+4)'(len_q);
        end
    end

    always_ff @(posedge fclk) begin
        if (!resetN) begin
            xptr_q    <= '0;
            wptr_q    <= '0;
            len_q     <= '0;
            rem_q     <= '0;
            gnt_q     <= 3'(NREQ - 1);
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            wr_en_q <= accept;
            err_q   <= (state_q == ARB) && bad_hit;
            if (accept) begin
                wr_addr_q <= xptr_q[AW-1:0];
                wr_data_q <= data_sel;
                xptr_q    <= xptr_q + (AW+1)'(1);
                rem_q     <= rem_q - (AW+1)'(1);
            end
            if (grant) begin
                gnt_q <= pick;
                len_q <= pick_len;
                rem_q <= pick_len;
            end
            if (state_q == COMMIT) begin
                wptr_q <= xptr_q;
            end
`ifdef IXC_IFIFO_ARB_WDOG_EN
            // Rewind discards the partial packet; nothing was published.
            if (state_q == ABORT) begin
                xptr_q <= wptr_q;
                err_q  <= 1'b1;
            end
`endif
        end
    end

`ifdef IXC_IFIFO_ARB_WDOG_EN
    always_ff @(posedge fclk) begin
        if (!resetN) begin
            stall_q <= '0;
        end else if (state_q != XFER || accept) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_q + 8'd1;
        end
    end

    assign stall_max = (stall_q == 8'hff);
`endif

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign wptr    = wptr_q;
    assign gnt_id  = gnt_q;
    assign err_len = err_q;

endmodule

// File: tb/tb_ixc_ififo_arb.sv
// tb_ixc_ififo_arb: directed and random packet traffic against a transaction-level
// round-robin/FIFO model; the stall test follows IXC_IFIFO_ARB_WDOG_EN.

module tb_ixc_ififo_arb;

    localparam int NREQ = 4;
    localparam int DW   = 16;
    localparam int AW   = 4;
    localparam int LENW = 8;

    logic                 fclk = 1'b0;
    logic                 resetN;
    logic                 GFlock;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*LENW-1:0] req_len;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic [AW:0]          rptr;
    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic [DW-1:0]        wr_data;
    logic [AW:0]          wptr;
    logic                 ackClk;
    logic [AW+3:0]        ackLen;
    logic [2:0]           gnt_id;
    logic                 err_len;

    ixc_ififo_arb #(
        .NREQ(NREQ),
        .DW  (DW),
        .AW  (AW),
        .LENW(LENW)
    ) dut (
        .fclk     (fclk),
        .resetN   (resetN),
        .GFlock   (GFlock),
        .req_valid(req_valid),
        .req_len  (req_len),
        .req_data (req_data),
        .req_ready(req_ready),
        .rptr     (rptr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wptr     (wptr),
        .ackClk   (ackClk),
        .ackLen   (ackLen),
        .gnt_id   (gnt_id),
        .err_len  (err_len)
    );

    always #5 fclk = ~fclk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // Requester side: what each channel still has to send.
    int            d_len[NREQ][$];
    logic [DW-1:0] d_dat[NREQ][$];
    int            dwi[NREQ];
    bit            hold[NREQ];
    int            hold_at[NREQ];
    logic [NREQ-1:0] acc;

    // Reference side: packets not yet committed, in arrival order.
    int            m_len[NREQ][$];
    logic [DW-1:0] m_dat[NREQ][$];
    bit            busy, wchk, follow, rnd;
    int            cur, last, widx, writes, acks, errs, t_wr;
    logic [AW:0]   mx, mw;
    int            ack_t[$];
    int            g_ord[$];

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_pkt(int r, int len);
        logic [DW-1:0] v;
        d_len[r].push_back(len);
        m_len[r].push_back(len);
        for (int w = 0; w < len; w++) begin
            v = DW'($urandom);
            d_dat[r].push_back(v);
            m_dat[r].push_back(v);
        end
    endtask

    function automatic int next_rr(int l);
        int idx;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (l + k) % NREQ;
            if (m_len[idx].size() > 0 && m_len[idx][0] >= 1 &&
                m_len[idx][0] <= (1 << AW)) begin
                return idx;
            end
        end
        return -1;
    endfunction

    task automatic monitor();
        logic [AW:0] occ;
        acc = req_valid & req_ready;
        if (!resetN) return;
        check("ready_onehot", 64'($onehot0(req_ready)), 1);
        if (err_len) errs++;
        if (wr_en) begin
            if (t_wr < 0) t_wr = cyc;
            if (!busy) begin
                cur = next_rr(last);
                if (cur >= 0) begin
                    busy = 1'b1;
                    widx = 0;
                    last = cur;
                end else begin
                    check("unexp_wr", wr_en, 0);
                end
            end
            if (busy) begin
                occ = mx - rptr;
                check("wr_addr", wr_addr, mx[AW-1:0]);
                check("wr_data", wr_data, m_dat[cur][widx]);
                check("no_overrun", 64'(occ < (AW+1)'(1 << AW)), 1);
                mx++;
                widx++;
            end
            writes++;
        end
        if (ackClk) begin
            if (busy) begin
                check("ack_len", ackLen, m_len[cur][0]);
                check("ack_last_word", 64'(widx == m_len[cur][0]), 1);
                for (int w = 0; w < m_len[cur][0]; w++) void'(m_dat[cur].pop_front());
                void'(m_len[cur].pop_front());
                busy = 1'b0;
            end else begin
                check("unexp_ack", ackClk, 0);
            end
            ack_t.push_back(cyc);
            g_ord.push_back(int'(gnt_id));
            acks++;
            mw = mx;
            wchk = 1'b1;
        end else if (wchk) begin
            check("wptr", wptr, mw);
            wchk = 1'b0;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            if (acc[i] && d_len[i].size() > 0) begin
                dwi[i]++;
                if (dwi[i] == d_len[i][0]) begin
                    for (int w = 0; w < d_len[i][0]; w++) void'(d_dat[i].pop_front());
                    void'(d_len[i].pop_front());
                    dwi[i] = 0;
                end
            end
            req_valid[i] = d_len[i].size() > 0 && !(hold[i] && dwi[i] == hold_at[i]);
            req_len[i*LENW +: LENW] = d_len[i].size() > 0 ? LENW'(d_len[i][0]) : '0;
            req_data[i*DW +: DW] = d_dat[i].size() > dwi[i] ? d_dat[i][dwi[i]] : '0;
        end
        if (follow) rptr = wptr;
        if (rnd) GFlock = ($urandom_range(0, 3) == 0);
    endtask

    task automatic step();
        @(negedge fclk);
        monitor();
        @(posedge fclk);
        cyc++;
        #1;
        drive();
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        GFlock = 1'b0;
        rnd    = 1'b0;
        follow = 1'b1;
        rptr   = '0;
        for (int i = 0; i < NREQ; i++) begin
            d_len[i].delete();
            d_dat[i].delete();
            m_len[i].delete();
            m_dat[i].delete();
            dwi[i]     = 0;
            hold[i]    = 1'b0;
            hold_at[i] = 0;
        end
        busy = 1'b0; wchk = 1'b0; mx = '0; mw = '0;
        last = NREQ - 1; cur = -1; widx = 0;
        writes = 0; acks = 0; errs = 0; t_wr = -1;
        ack_t.delete();
        g_ord.delete();
        drive();
        step();
        step();
        resetN = 1'b1;
    endtask

    task automatic reset_values(string tag);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_wr_en"}, wr_en, 0);
        check({tag, "_wr_addr"}, wr_addr, 0);
        check({tag, "_wr_data"}, wr_data, 0);
        check({tag, "_wptr"}, wptr, 0);
        check({tag, "_ackClk"}, ackClk, 0);
        check({tag, "_ackLen"}, ackLen, 0);
        check({tag, "_gnt_id"}, gnt_id, NREQ - 1);
        check({tag, "_err_len"}, err_len, 0);
    endtask

    initial begin
        int t0;
        int n;
        int total;
        int exp_o[5];
        exp_o = '{0, 1, 2, 3, 0};
        req_valid = '0;
        req_len   = '0;
        req_data  = '0;

        // Reset state, then a single 3-word packet with its grant latency.
        do_reset();
        reset_values("rst");
        push_pkt(0, 3);
        step();
        t0 = cyc;
        for (n = 0; n < 40 && acks < 1; n++) step();
        step();
        check("single_acks", acks, 1);
        check("single_latency", 64'(t_wr - t0), 3);
        check("single_writes", writes, 3);
        check("single_wptr", wptr, 3);

        // Round robin over all four, one word each.
        do_reset();
        push_pkt(0, 1);
        push_pkt(0, 1);
        for (int i = 1; i < NREQ; i++) push_pkt(i, 1);
        for (n = 0; n < 80 && acks < 5; n++) step();
        step();
        check("rr_acks", acks, 5);
        for (int k = 0; k < 5; k++) check("rr_order", g_ord[k], exp_o[k]);
        for (int k = 1; k < 5; k++) check("rr_ack_gap", 64'(ack_t[k] - ack_t[k-1]), 3);

        // Full FIFO blocks the second packet until the consumer frees room.
        do_reset();
        follow = 1'b0;
        push_pkt(0, 16);
        push_pkt(1, 2);
        for (n = 0; n < 60 && acks < 1; n++) step();
        repeat (10) step();
        check("full_writes", writes, 16);
        check("full_ready", req_ready, 0);
        check("full_wptr", wptr, 16);
        rptr = 5'd2;
        for (n = 0; n < 5 && writes < 17; n++) step();
        check("space_grant", 64'(writes >= 17), 1);
        for (n = 0; n < 20 && acks < 2; n++) step();
        step();
        check("space_wptr_wrap", wptr, 18);

        // Zero and oversize lengths are rejected; the others still flow.
        do_reset();
        push_pkt(0, 2);
        push_pkt(1, 3);
        push_pkt(2, 0);
        push_pkt(3, 17);
        for (n = 0; n < 60 && acks < 2; n++) step();
        repeat (10) step();
        check("badlen_acks", acks, 2);
        check("badlen_writes", writes, 5);
        check("badlen_err_seen", 64'(errs > 0), 1);

        // Reset in the middle of a packet drops it without an ack.
        do_reset();
        push_pkt(0, 5);
        for (n = 0; n < 20 && writes < 2; n++) step();
        check("midrst_reached", 64'(writes >= 2), 1);
        check("midrst_noack", acks, 0);
        do_reset();
        reset_values("midrst");
        push_pkt(1, 1);
        for (n = 0; n < 30 && acks < 1; n++) step();
        step();
        check("midrst_next_acks", acks, 1);
        check("midrst_next_wptr", wptr, 1);

        // Requester stalls after its first word.
        do_reset();
        hold[0]    = 1'b1;
        hold_at[0] = 1;
        push_pkt(0, 4);
`ifdef IXC_IFIFO_ARB_WDOG_EN
        repeat (300) step();
        check("wdog_err", errs, 1);
        check("wdog_noack", acks, 0);
        check("wdog_writes", writes, 1);
        hold[0] = 1'b0;
        d_len[0].delete();
        d_dat[0].delete();
        m_len[0].delete();
        m_dat[0].delete();
        dwi[0] = 0;
        busy = 1'b0;
        mx = mw;
        push_pkt(1, 2);
        for (n = 0; n < 40 && acks < 1; n++) step();
        step();
        check("wdog_next_acks", acks, 1);
        check("wdog_rewind_wptr", wptr, 2);
`else
        repeat (1000) step();
        check("stall_no_err", errs, 0);
        check("stall_noack", acks, 0);
        check("stall_writes", writes, 1);
        hold[0] = 1'b0;
        for (n = 0; n < 20 && acks < 1; n++) step();
        step();
        check("stall_resume_acks", acks, 1);
        check("stall_resume_wptr", wptr, 4);
`endif

        // Random packet mixes with random GFlock and a prompt consumer.
        do_reset();
        rnd   = 1'b1;
        total = 0;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < NREQ; i++) begin
                n = $urandom_range(0, 5);
                for (int p = 0; p < n; p++) push_pkt(i, $urandom_range(1, 16));
                total += n;
            end
            for (n = 0; n < 3000 && acks < total; n++) step();
            repeat (3) step();
            check("rnd_acks", acks, total);
        end
        rnd    = 1'b0;
        GFlock = 1'b0;
        check("rnd_no_err", errs, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
